// File: rtl/apb_uart_req_arbiter.sv
// Round-robin arbiter sharing the UART core's single APB slave port between NUM_REQ requesters.
// Each grant runs one full SETUP/ACCESS transfer with a Pready timeout guard and a one-cycle ack.
module apb_uart_req_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      clk,
    input  logic                      Preset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         Paddr,
    output logic                      Psel,
    output logic                      Penable,
    output logic                      Pwrite,
    output logic [DATA_W-1:0]         Pwdata,
    input  logic [DATA_W-1:0]         Prdata,
    input  logic                      Pready,
    input  logic                      Pslverr
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant;
    logic [CNT_W-1:0]   count;
    logic [IDX_W-1:0]   pick;
    logic               any_req;
    logic               timeout_hit;
    int                 idx;

    // Scan offsets from the highest down so the set bit closest to rr_ptr wins.
    always_comb begin
        pick    = rr_ptr;
        any_req = 1'b0;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                pick    = IDX_W'(idx);
                any_req = 1'b1;
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYC != 0) && ((int'(count) + 1) == TIMEOUT_CYC);

    always_ff @(posedge clk or posedge Preset) begin
        if (Preset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            count     <= '0;
            ack       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            Paddr     <= '0;
            Psel      <= 1'b0;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Pwdata    <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant   <= pick;
                        Paddr   <= req_addr[pick*ADDR_W +: ADDR_W];
                        Pwdata  <= req_wdata[pick*DATA_W +: DATA_W];
                        Pwrite  <= req_write[pick];
                        Psel    <= 1'b1;
                        Penable <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    Penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (Pready || timeout_hit) begin
                        // A real Pready wins over a timeout landing on the same cycle.
                        ack[grant] <= 1'b1;
                        rsp_err    <= Pready ? Pslverr : 1'b1;
                        rsp_rdata  <= (Pready && !Pwrite) ? Prdata : '0;
                        Psel       <= 1'b0;
                        Penable    <= 1'b0;
                        count      <= '0;
                        rr_ptr     <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
                        state      <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_req_arbiter.sv
// Bench for apb_uart_req_arbiter: directed scenarios plus randomized transfers checked
// against a transaction-level round-robin/APB model.
module tb_apb_uart_req_arbiter;

    localparam int NUM_REQ     = 2;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 16;

    logic                      clk = 1'b0;
    logic                      Preset = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic [ADDR_W-1:0]         Paddr;
    logic                      Psel;
    logic                      Penable;
    logic                      Pwrite;
    logic [DATA_W-1:0]         Pwdata;
    logic [DATA_W-1:0]         Prdata = '0;
    logic                      Pready = 1'b0;
    logic                      Pslverr = 1'b0;

    logic [ADDR_W-1:0] pay_addr  [NUM_REQ];
    logic [DATA_W-1:0] pay_wdata [NUM_REQ];
    logic              pay_write [NUM_REQ];

    int n_checks = 0;
    int n_pass   = 0;
    int model_rr = 0;
    logic [DATA_W:0] exp_q[$];

    always #5 clk = ~clk;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        req_write = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W]  = pay_addr[i];
            req_wdata[i*DATA_W +: DATA_W] = pay_wdata[i];
            req_write[i]                  = pay_write[i];
        end
    end

    apb_uart_req_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .Preset(Preset), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .Paddr(Paddr), .Psel(Psel),
        .Penable(Penable), .Pwrite(Pwrite), .Pwdata(Pwdata), .Prdata(Prdata),
        .Pready(Pready), .Pslverr(Pslverr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic randomize_payloads();
        for (int i = 0; i < NUM_REQ; i++) begin
            pay_addr[i]  = ($urandom() & 32'hFFFF_FF00) | (i * 4);
            pay_wdata[i] = $urandom();
            pay_write[i] = 1'($urandom_range(0, 1));
        end
    endtask

    // Starts on a falling edge with the DUT idle and req already driven; ends on the
    // falling edge of the idle cycle following DONE.
    task automatic xfer(input int waits, input logic slverr, input logic [DATA_W-1:0] rdata,
                        input bit drop_req, input logic [NUM_REQ-1:0] next_req);
        int                 g;
        int                 access_cycles;
        bit                 timed_out;
        logic [NUM_REQ-1:0] exp_ack;
        logic [DATA_W:0]    exp_rsp;
        logic [ADDR_W-1:0]  a;
        g = -1;
        for (int k = 0; k < NUM_REQ; k++)
            if (g < 0 && req[(model_rr + k) % NUM_REQ]) g = (model_rr + k) % NUM_REQ;
        check("grant_found", 64'(g >= 0), 64'd1);
        if (g < 0) g = 0;
        a = pay_addr[g];

        @(posedge clk); @(negedge clk);
        check("setup_psel", Psel, 1);
        check("setup_penable", Penable, 0);
        check("setup_paddr", Paddr, a);
        check("setup_pwrite", Pwrite, pay_write[g]);
        check("setup_pwdata", Pwdata, pay_wdata[g]);
        check("setup_ack", ack, 0);

        @(posedge clk); @(negedge clk);
        timed_out     = 0;
        access_cycles = 0;
        for (int c = 0; c < 64; c++) begin
            check("access_psel", Psel, 1);
            check("access_penable", Penable, 1);
            check("access_paddr", Paddr, a);
            check("access_ack", ack, 0);
            if (drop_req && c == 0) req[g] = 1'b0;
            Pready  = (c >= waits);
            Prdata  = rdata;
            Pslverr = slverr;
            access_cycles++;
            @(posedge clk); @(negedge clk);
            if (c >= waits) break;
            if (TIMEOUT_CYC != 0 && access_cycles == TIMEOUT_CYC) begin
                timed_out = 1;
                break;
            end
        end
        check("access_bounded", 64'(timed_out || access_cycles == waits + 1), 64'd1);
        Pready  = 1'b0;
        Pslverr = 1'b0;
        Prdata  = $urandom();

        exp_q.push_back({timed_out ? 1'b1 : slverr,
                         (timed_out || pay_write[g]) ? {DATA_W{1'b0}} : rdata});
        exp_rsp    = exp_q.pop_front();
        exp_ack    = '0;
        exp_ack[g] = 1'b1;
        check("done_ack", ack, exp_ack);
        check("done_rsp_err", rsp_err, exp_rsp[DATA_W]);
        check("done_rsp_rdata", rsp_rdata, exp_rsp[DATA_W-1:0]);
        check("done_psel", Psel, 0);
        check("done_penable", Penable, 0);
        model_rr = (g + 1) % NUM_REQ;
        req = next_req;

        @(posedge clk); @(negedge clk);
        check("idle_ack", ack, 0);
        check("idle_psel", Psel, 0);
        check("idle_rsp_hold", {rsp_err, rsp_rdata}, exp_rsp);
        check("idle_paddr_hold", Paddr, a);
    endtask

    initial begin
        randomize_payloads();
        #1 Preset = 1'b1;
        #1;
        check("reset_psel", Psel, 0);
        check("reset_penable", Penable, 0);
        check("reset_ack", ack, 0);
        check("reset_paddr", Paddr, 0);
        check("reset_pwdata", Pwdata, 0);
        check("reset_rsp", {rsp_err, rsp_rdata}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        Preset = 1'b0;

        // No request: stays idle.
        @(posedge clk); @(negedge clk);
        check("noreq_psel", Psel, 0);

        // Write from requester 0.
        pay_addr[0] = 32'h08; pay_wdata[0] = 32'hA5; pay_write[0] = 1'b1;
        pay_addr[1] = 32'h0C; pay_wdata[1] = 32'h77; pay_write[1] = 1'b0;
        req = 2'b01;
        xfer(0, 1'b0, 32'hDEAD_BEEF, 0, 2'b00);

        // Read from requester 1 with three wait states.
        req = 2'b10;
        xfer(3, 1'b0, 32'h55, 0, 2'b00);

        // Both held: alternating grants, back to back.
        req = 2'b11;
        for (int t = 0; t < 6; t++) xfer(0, 1'b0, $urandom(), 0, 2'b11);
        req = 2'b00;

        // Pready stuck low: timeout, then a normal transfer.
        req = 2'b01;
        pay_write[0] = 1'b0;
        xfer(100, 1'b0, 32'h1234, 0, 2'b00);
        req = 2'b10;
        xfer(1, 1'b0, 32'h4321, 0, 2'b00);

        // Slave error on a write, then a clean write.
        pay_write[0] = 1'b1;
        req = 2'b01;
        xfer(0, 1'b1, 32'h0, 0, 2'b00);
        req = 2'b01;
        xfer(0, 1'b0, 32'h0, 0, 2'b00);

        // Randomized transfers, including dropped requests and timeouts.
        for (int t = 0; t < 24; t++) begin
            randomize_payloads();
            req = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            xfer(($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), $urandom(), $urandom_range(0, 3) == 0,
                 NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1)));
        end

        // Leave rr pointing at requester 1, then reset mid-ACCESS.
        randomize_payloads();
        req = 2'b01;
        xfer(0, 1'b0, 32'h0, 0, 2'b00);
        req = 2'b01;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("pre_reset_penable", Penable, 1);
        #1 Preset = 1'b1;
        #1;
        check("midreset_psel", Psel, 0);
        check("midreset_penable", Penable, 0);
        check("midreset_ack", ack, 0);
        check("midreset_paddr", Paddr, 0);
        req = 2'b11;
        @(posedge clk); @(negedge clk);
        check("inreset_ack", ack, 0);
        Preset   = 1'b0;
        model_rr = 0;
        xfer(0, 1'b0, $urandom(), 0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
